// File: rtl/fetch_unit_pkg.sv
// Shared instruction-format definitions used by both the fetch unit and the
// instruction decoder, so the two always agree on instruction length.
//   INST_TWO_BYTE_BIT : bit of the 16-bit instruction word that selects
//                       2-byte length (lives in the opcode byte).
//   inst_bytes()      : number of bytes (1 or 2) for a given opcode byte.
package fetch_unit_pkg;

  localparam int unsigned INST_TWO_BYTE_BIT = 15;
  localparam int unsigned OPC_LEN_BIT       = INST_TWO_BYTE_BIT - 8;

  function automatic logic [1:0] inst_bytes(input logic [7:0] opcode);
    return opcode[OPC_LEN_BIT] ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetcher. Fetches the opcode byte (and, for 2-byte
// instructions, the immediate byte) over a req/ack byte memory port, holds the
// assembled 16-bit instruction for the decoder, optionally fetches one data
// byte for the held instruction, and owns the PC including redirects.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mem_req/mem_addr      read request and address (decoded from state/PC)
//   mem_ack/mem_rdata     read completion and data
//   pc_load/pc_target     redirect strobe and target
//   inst_valid/inst/inst_pc  held instruction and its opcode address
//   inst_ready            consumer retires the held instruction
//   data_req/data_addr    request a data byte while holding an instruction
//   data_valid/data       fetched data byte
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready,
  input  logic        data_req,
  input  logic [15:0] data_addr,
  output logic        data_valid,
  output logic [7:0]  data
);

  typedef enum logic [1:0] {
    FETCH_HI   = 2'd0,
    FETCH_LO   = 2'd1,
    HOLD       = 2'd2,
    FETCH_DATA = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] daddr_q, daddr_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        redir_pend_q, redir_pend_d;
  logic [15:0] redir_tgt_q, redir_tgt_d;

  // A redirect takes effect at the end of an outstanding handshake either
  // because it was recorded earlier or because it arrives in the ack cycle;
  // the newest target wins.
  logic        redirect_now;
  logic [15:0] redirect_pc;

  assign redirect_now = pc_load | redir_pend_q;
  assign redirect_pc  = pc_load ? pc_target : redir_tgt_q;

  // Request is combinational from state so it appears in the first cycle
  // after reset falls; gated by rst so the reset cycle itself is idle.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = RESET_PC;
    if (!rst) begin
      mem_req  = (state_q != HOLD);
      mem_addr = (state_q == FETCH_DATA) ? daddr_q : pc_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    daddr_d      = daddr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;

    unique case (state_q)
      FETCH_HI: begin
        if (mem_ack) begin
          if (redirect_now) begin
            state_d      = FETCH_HI;
            pc_d         = redirect_pc;
            redir_pend_d = 1'b0;
          end else begin
            inst_d[15:8] = mem_rdata;
            inst_pc_d    = pc_q;
            pc_d         = pc_q + 16'd1;
            if (inst_bytes(mem_rdata) == 2'd2) begin
              state_d = FETCH_LO;
            end else begin
              inst_d[7:0]  = 8'h00;
              inst_valid_d = 1'b1;
              state_d      = HOLD;
            end
          end
        end else if (pc_load) begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = pc_target;
        end
      end

      FETCH_LO: begin
        if (mem_ack) begin
          if (redirect_now) begin
            state_d      = FETCH_HI;
            pc_d         = redirect_pc;
            redir_pend_d = 1'b0;
          end else begin
            inst_d[7:0]  = mem_rdata;
            pc_d         = pc_q + 16'd1;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (pc_load) begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = pc_target;
        end
      end

      HOLD: begin
        if (pc_load) begin
          pc_d         = pc_target;
          inst_valid_d = 1'b0;
          data_valid_d = 1'b0;
          state_d      = FETCH_HI;
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
          data_valid_d = 1'b0;
          state_d      = FETCH_HI;
        end else if (data_req) begin
          daddr_d = data_addr;
          state_d = FETCH_DATA;
        end
      end

      FETCH_DATA: begin
        // The held instruction is dropped as soon as a redirect arrives,
        // even though the data handshake must still run to completion.
        if (pc_load) begin
          inst_valid_d = 1'b0;
          data_valid_d = 1'b0;
        end
        if (mem_ack) begin
          if (redirect_now) begin
            state_d      = FETCH_HI;
            pc_d         = redirect_pc;
            redir_pend_d = 1'b0;
          end else begin
            data_d       = mem_rdata;
            data_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (pc_load) begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = pc_target;
        end
      end

      default: state_d = FETCH_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_HI;
      pc_q         <= RESET_PC;
      daddr_q      <= '0;
      inst_q       <= '0;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      daddr_q      <= daddr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign data_valid = data_valid_q;
  assign data       = data_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        data_req;
  logic [15:0] data_addr;
  logic        data_valid;
  logic [7:0]  data;

  int unsigned n_tests;
  int unsigned n_fail;

  // Memory model: ack after 'waits' stall cycles; spur_ack injects an ack
  // while no request is outstanding.
  logic [7:0]  mem [65536];
  int unsigned waits;
  int unsigned wcnt;
  logic        spur_ack;

  assign mem_ack   = (mem_req && (wcnt == waits)) || spur_ack;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) wcnt <= 0;
    else                            wcnt <= wcnt + 1;
  end

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .data_req   (data_req),
    .data_addr  (data_addr),
    .data_valid (data_valid),
    .data       (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    pc_load    = 1'b0;
    pc_target  = '0;
    inst_ready = 1'b0;
    data_req   = 1'b0;
    data_addr  = '0;
    spur_ack   = 1'b0;
    waits      = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // Reset values
    tick();
    tick();
    chk("rst_mem_req",    {15'd0, mem_req},    16'h0000);
    chk("rst_mem_addr",   mem_addr,            16'h0000);
    chk("rst_inst_valid", {15'd0, inst_valid}, 16'h0000);
    chk("rst_inst",       inst,                16'h0000);
    chk("rst_inst_pc",    inst_pc,             16'h0000);
    chk("rst_data_valid", {15'd0, data_valid}, 16'h0000);
    chk("rst_data",       {8'd0, data},        16'h0000);

    // 1-byte fetch, zero-wait memory, inst_ready held
    mem[0]     = 8'h01;
    inst_ready = 1'b1;
    rst        = 1'b0;
    #1;
    chk("t1_first_req",   {15'd0, mem_req},    16'h0001);
    chk("t1_first_addr",  mem_addr,            16'h0000);
    tick();
    chk("t1_valid",       {15'd0, inst_valid}, 16'h0001);
    chk("t1_inst",        inst,                16'h0100);
    chk("t1_inst_pc",     inst_pc,             16'h0000);
    chk("t1_hold_noreq",  {15'd0, mem_req},    16'h0000);
    tick();
    chk("t1_next_addr",   mem_addr,            16'h0001);
    chk("t1_next_req",    {15'd0, mem_req},    16'h0001);
    chk("t1_valid_drop",  {15'd0, inst_valid}, 16'h0000);

    // 2-byte fetch with 2 wait states per byte
    inst_ready = 1'b0;
    rst        = 1'b1;
    tick();
    mem[0] = 8'h80;
    mem[1] = 8'h2A;
    waits  = 2;
    rst    = 1'b0;
    tick();
    chk("t2_wait_addr",   mem_addr,            16'h0000);
    chk("t2_wait_req",    {15'd0, mem_req},    16'h0001);
    tick();
    chk("t2_wait_addr2",  mem_addr,            16'h0000);
    tick();
    chk("t2_lo_addr",     mem_addr,            16'h0001);
    tick();
    tick();
    chk("t2_not_yet",     {15'd0, inst_valid}, 16'h0000);
    tick();
    chk("t2_valid",       {15'd0, inst_valid}, 16'h0001);
    chk("t2_inst",        inst,                16'h802A);
    chk("t2_inst_pc",     inst_pc,             16'h0000);

    // Data fetch on the held instruction
    mem[16'h1234] = 8'h5A;
    waits     = 0;
    data_req  = 1'b1;
    data_addr = 16'h1234;
    tick();
    data_req   = 1'b0;
    inst_ready = 1'b1;   // must be ignored while the data fetch is in flight
    chk("d_addr",         mem_addr,            16'h1234);
    chk("d_inst_valid",   {15'd0, inst_valid}, 16'h0001);
    chk("d_not_yet",      {15'd0, data_valid}, 16'h0000);
    tick();
    chk("d_valid",        {15'd0, data_valid}, 16'h0001);
    chk("d_data",         {8'd0, data},        16'h005A);
    chk("d_inst_stable",  inst,                16'h802A);
    chk("d_ready_ignored",{15'd0, inst_valid}, 16'h0001);
    tick();
    inst_ready = 1'b0;
    chk("d_clear_iv",     {15'd0, inst_valid}, 16'h0000);
    chk("d_clear_dv",     {15'd0, data_valid}, 16'h0000);
    chk("d_pc_after2b",   mem_addr,            16'h0002);
    tick();
    chk("h2_inst",        inst,                16'h0000);
    chk("h2_inst_pc",     inst_pc,             16'h0002);

    // Simultaneous inst_ready and data_req: retire wins
    inst_ready = 1'b1;
    data_req   = 1'b1;
    data_addr  = 16'h1234;
    tick();
    inst_ready = 1'b0;
    data_req   = 1'b0;
    chk("prio_addr",      mem_addr,            16'h0003);
    tick();
    chk("prio_hold",      {15'd0, inst_valid}, 16'h0001);

    // Ack without a request is ignored
    mem[16'h0003] = 8'h00;
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    chk("spur_valid",     {15'd0, inst_valid}, 16'h0001);
    chk("spur_inst_pc",   inst_pc,             16'h0003);
    chk("spur_noreq",     {15'd0, mem_req},    16'h0000);

    // Redirect during an outstanding FETCH_LO, target overwritten once
    mem[4]        = 8'h81;
    mem[5]        = 8'h33;
    mem[16'h0040] = 8'h05;
    waits      = 2;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("r_hi_addr",      mem_addr,            16'h0004);
    tick();
    tick();
    tick();
    chk("r_lo_addr",      mem_addr,            16'h0005);
    pc_load   = 1'b1;
    pc_target = 16'h0030;
    tick();
    pc_target = 16'h0040;
    chk("r_addr_stable",  mem_addr,            16'h0005);
    chk("r_req_held",     {15'd0, mem_req},    16'h0001);
    tick();
    pc_load = 1'b0;
    tick();
    chk("r_target_addr",  mem_addr,            16'h0040);
    chk("r_no_valid",     {15'd0, inst_valid}, 16'h0000);
    waits = 0;
    tick();
    chk("r_inst",         inst,                16'h0500);
    chk("r_inst_pc",      inst_pc,             16'h0040);

    // Data fetch, then redirect from HOLD (pc_load beats inst_ready)
    mem[16'h0100] = 8'hC3;
    data_req  = 1'b1;
    data_addr = 16'h0100;
    tick();
    data_req = 1'b0;
    tick();
    chk("hd_data",        {8'd0, data},        16'h00C3);
    mem[16'hFFFF] = 8'h88;
    mem[16'h0000] = 8'h07;
    pc_load    = 1'b1;
    pc_target  = 16'hFFFF;
    inst_ready = 1'b1;
    tick();
    pc_load    = 1'b0;
    inst_ready = 1'b0;
    chk("hr_addr",        mem_addr,            16'hFFFF);
    chk("hr_iv_drop",     {15'd0, inst_valid}, 16'h0000);
    chk("hr_dv_drop",     {15'd0, data_valid}, 16'h0000);

    // Wrap-around of a 2-byte instruction at 16'hFFFF
    tick();
    chk("w_lo_addr",      mem_addr,            16'h0000);
    tick();
    chk("w_inst",         inst,                16'h8807);
    chk("w_inst_pc",      inst_pc,             16'hFFFF);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("w_next_pc",      mem_addr,            16'h0001);

    // Reset in the middle of a waiting FETCH_HI
    waits = 3;
    tick();
    rst = 1'b1;
    #1;
    chk("mr_req_low",     {15'd0, mem_req},    16'h0000);
    chk("mr_addr_rst",    mem_addr,            16'h0000);
    tick();
    chk("mr_inst",        inst,                16'h0000);
    chk("mr_inst_pc",     inst_pc,             16'h0000);
    chk("mr_data",        {8'd0, data},        16'h0000);
    chk("mr_iv",          {15'd0, inst_valid}, 16'h0000);
    waits = 0;
    rst   = 1'b0;
    #1;
    chk("mr_req_again",   {15'd0, mem_req},    16'h0001);
    chk("mr_addr_again",  mem_addr,            16'h0000);
    tick();
    chk("mr_inst_after",  inst,                16'h0700);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
